// File: rtl/lbm_pkg.sv
// Shared lattice constants and types for the LBM display reader and the LBM controller.
package lbm_pkg;
   localparam int GRID_W        = 192;
   localparam int GRID_H        = 192;
   localparam int LATTICE_DEPTH = GRID_W * GRID_H;

   localparam logic [23:0] BORDER_RGB = 24'h202020;

   typedef logic [15:0] lattice_addr_t;

   typedef enum logic {
      SWAP_IDLE,
      SWAP_PENDING
   } swap_state_e;

   // Side-band bits that ride alongside a pixel through the read pipeline.
   typedef struct packed {
      logic hsync;
      logic vsync;
      logic active;
      logic in_region;
      logic valid;
   } vid_tag_t;
endpackage

// File: rtl/lbm_display_reader_if.sv
// Video timing, swap handshake, BRAM read port and pixel output of the LBM display reader.
interface lbm_display_reader_if
   import lbm_pkg::*;
#(
   parameter int DATA_W = 16
);
   logic [10:0]       hcount_in;
   logic [9:0]        vcount_in;
   logic              hsync_in;
   logic              vsync_in;
   logic              active_in;
   logic              swap_req_in;
   logic              swap_ack_out;
   logic              bank_out;
   lattice_addr_t     addr_out;
   logic [DATA_W-1:0] data_in;
   logic [23:0]       pixel_out;
   logic              hsync_out;
   logic              vsync_out;
   logic              active_out;

   modport master (
      output hcount_in, vcount_in, hsync_in, vsync_in, active_in, swap_req_in, data_in,
      input  swap_ack_out, bank_out, addr_out, pixel_out, hsync_out, vsync_out, active_out
   );

   modport slave (
      input  hcount_in, vcount_in, hsync_in, vsync_in, active_in, swap_req_in, data_in,
      output swap_ack_out, bank_out, addr_out, pixel_out, hsync_out, vsync_out, active_out
   );
endinterface

// File: rtl/lbm_colormap.sv
// Registered magnitude-to-RGB map, one cycle. Define LBM_HEATMAP_EN for a blue->green->red
// ramp; otherwise the magnitude is shown as grayscale.
module lbm_colormap (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [7:0]  mag_in,
   output logic [23:0] rgb_out
);
   logic [23:0] rgb_q, rgb_d;

`ifdef LBM_HEATMAP_EN
   logic [7:0] seg, ramp;

   always_comb begin
      seg  = (mag_in < 8'd85) ? mag_in : mag_in - 8'd85;
      ramp = seg + seg + seg;
      if (mag_in < 8'd85)
         rgb_d = {8'd0, ramp, 8'd255 - ramp};
      else if (mag_in < 8'd170)
         rgb_d = {ramp, 8'd255 - ramp, 8'd0};
      else
         rgb_d = {8'd255, 16'd0};
   end
`else
   assign rgb_d = {3{mag_in}};
`endif

   always_ff @(posedge clk_in) begin
      if (rst_in) rgb_q <= '0;
      else        rgb_q <= rgb_d;
   end

   assign rgb_out = rgb_q;
endmodule

// File: rtl/lbm_display_reader.sv
// Lattice display read path: screen position -> BRAM address -> RGB, with bank swap at vsync.
// Colour mapping is selected by LBM_HEATMAP_EN inside lbm_colormap.
//
//   state        | meaning
//   SWAP_IDLE    | no step-done request outstanding
//   SWAP_PENDING | request seen, bank toggles on the next vsync rise
module lbm_display_reader
   import lbm_pkg::*;
#(
   parameter int SCALE  = 3,
   parameter int X0     = 352,
   parameter int Y0     = 72,
   parameter int DATA_W = 16
) (
   input  logic clk_in,
   input  logic rst_in,
   lbm_display_reader_if.slave bus
);
   localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;
   localparam int COL_W = $clog2(GRID_W + 1);
   localparam logic [10:0]      H_CLR    = 11'(X0 - 1);
   localparam logic [10:0]      H_LO     = 11'(X0);
   localparam logic [10:0]      H_HI     = 11'(X0 + GRID_W * SCALE);
   localparam logic [9:0]       V_LO     = 10'(Y0);
   localparam logic [9:0]       V_HI     = 10'(Y0 + GRID_H * SCALE);
   localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SCALE - 1);
   localparam lattice_addr_t    ROW_STEP = lattice_addr_t'(GRID_W);

   logic [COL_W-1:0] col_q, col_d;
   logic [SUB_W-1:0] xsub_q, xsub_d, ysub_q, ysub_d;
   lattice_addr_t    row_base_q, row_base_d, addr_q, addr_d;
   logic             frame_valid_q, frame_valid_d;
   logic             vs_prev_q, vs_prev_d;
   logic             bank_q, bank_d, ack_q, ack_d;
   swap_state_e      state_q, state_d;
   vid_tag_t         tag_in;
   vid_tag_t [3:0]   tag_q, tag_d;

   logic        in_region, line_start, frame_start, vsync_rise;
   logic [23:0] rgb;
   logic        unused_data_lsbs;

   assign in_region   = (bus.hcount_in >= H_LO) && (bus.hcount_in < H_HI) &&
                        (bus.vcount_in >= V_LO) && (bus.vcount_in < V_HI);
   assign line_start  = (bus.hcount_in == '0);
   assign frame_start = line_start && (bus.vcount_in == '0);
   assign vsync_rise  = bus.vsync_in && !vs_prev_q;

   // Address walks by counting sub-pixels, so no multiply is needed for row*GRID_W + col.
   always_comb begin
      col_d      = col_q;
      xsub_d     = xsub_q;
      row_base_d = row_base_q;
      ysub_d     = ysub_q;
      addr_d     = addr_q;
      if (bus.hcount_in == H_CLR) begin
         col_d  = '0;
         xsub_d = '0;
      end else if (in_region) begin
         addr_d = row_base_q + lattice_addr_t'(col_q);
         if (xsub_q == SUB_LAST) begin
            xsub_d = '0;
            col_d  = col_q + COL_W'(1);
         end else begin
            xsub_d = xsub_q + SUB_W'(1);
         end
      end
      if (frame_start) begin
         row_base_d = '0;
         ysub_d     = '0;
      end else if (line_start && (bus.vcount_in > V_LO) && (bus.vcount_in <= V_HI)) begin
         if (ysub_q == SUB_LAST) begin
            ysub_d     = '0;
            row_base_d = row_base_q + ROW_STEP;
         end else begin
            ysub_d = ysub_q + SUB_W'(1);
         end
      end
   end

   // Pixels stay black after a reset until a frame is seen from its first line.
   always_comb begin
      frame_valid_d    = frame_valid_q | frame_start;
      tag_in           = '0;
      tag_in.hsync     = bus.hsync_in;
      tag_in.vsync     = bus.vsync_in;
      tag_in.active    = bus.active_in;
      tag_in.in_region = in_region;
      tag_in.valid     = frame_valid_d;
      tag_d            = {tag_q[2:0], tag_in};
      vs_prev_d        = bus.vsync_in;
   end

   always_comb begin
      state_d = state_q;
      bank_d  = bank_q;
      ack_d   = 1'b0;
      if (vsync_rise && ((state_q == SWAP_PENDING) || bus.swap_req_in)) begin
         bank_d  = ~bank_q;
         ack_d   = 1'b1;
         state_d = SWAP_IDLE;
      end else if (bus.swap_req_in) begin
         state_d = SWAP_PENDING;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         col_q         <= '0;
         xsub_q        <= '0;
         row_base_q    <= '0;
         ysub_q        <= '0;
         addr_q        <= '0;
         frame_valid_q <= 1'b0;
         vs_prev_q     <= 1'b0;
         tag_q         <= '0;
         state_q       <= SWAP_IDLE;
         bank_q        <= 1'b0;
         ack_q         <= 1'b0;
      end else begin
         col_q         <= col_d;
         xsub_q        <= xsub_d;
         row_base_q    <= row_base_d;
         ysub_q        <= ysub_d;
         addr_q        <= addr_d;
         frame_valid_q <= frame_valid_d;
         vs_prev_q     <= vs_prev_d;
         tag_q         <= tag_d;
         state_q       <= state_d;
         bank_q        <= bank_d;
         ack_q         <= ack_d;
      end
   end

   lbm_colormap u_colormap (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .mag_in  (bus.data_in[DATA_W-1 -: 8]),
      .rgb_out (rgb)
   );

   assign unused_data_lsbs = ^bus.data_in[DATA_W-9:0];

   assign bus.addr_out     = addr_q;
   assign bus.bank_out     = bank_q;
   assign bus.swap_ack_out = ack_q;
   assign bus.hsync_out    = tag_q[3].hsync;
   assign bus.vsync_out    = tag_q[3].vsync;
   assign bus.active_out   = tag_q[3].active;
   assign bus.pixel_out    = !tag_q[3].valid    ? 24'h0 :
                             tag_q[3].in_region ? rgb   : BORDER_RGB;
endmodule

// File: tb/tb_lbm_display_reader.sv
// Raster-driven bench for lbm_display_reader: reduced frames, random syncs and line spans,
// a BRAM model with 2-cycle latency and a reference model built from screen geometry.
module tb_lbm_display_reader;
   import lbm_pkg::*;

   localparam int SCALE = 3;
   localparam int X0    = 352;
   localparam int Y0    = 72;

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        act;
      logic [23:0] px;
   } exp_t;

   logic clk_in = 1'b0;
   logic rst_in;
   always #5 clk_in = ~clk_in;

   lbm_display_reader_if #(.DATA_W(16)) bus ();

   lbm_display_reader dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus)
   );

   int unsigned salt;
   int          n_vec = 0;
   int          n_err = 0;

   logic        m_valid, m_known, m_bank, m_pend, m_prev_vs, m_ack;
   logic [15:0] m_addr;
   exp_t        pipe [4];

   function automatic logic [7:0] mag_of(input logic [15:0] a);
      logic [31:0] t;
      if (a == 16'd0) return 8'h80;
      t = (32'(a) * 32'd37) ^ salt;
      return t[7:0];
   endfunction

   function automatic logic [23:0] colour(input int m);
`ifdef LBM_HEATMAP_EN
      if (m < 85)       return {8'd0, 8'(3 * m), 8'(255 - 3 * m)};
      else if (m < 170) return {8'(3 * (m - 85)), 8'(255 - 3 * (m - 85)), 8'd0};
      else              return 24'hFF0000;
`else
      return {8'(m), 8'(m), 8'(m)};
`endif
   endfunction

   // BRAM: address seen in cycle k returns data in cycle k+2.
   logic [15:0] rd1;
   always @(posedge clk_in) begin
      rd1         <= {mag_of(bus.addr_out), bus.addr_out[7:0]};
      bus.data_in <= rd1;
   end

   task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp_v);
      n_vec++;
      assert (obs === exp_v)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h (h=%0d v=%0d)", tag, obs, exp_v,
                bus.hcount_in, bus.vcount_in);
      end
   endtask

   task automatic step(input bit rst, input int h, input int v, input bit hs, input bit vs,
                       input bit act, input bit req);
      bit          region;
      logic [23:0] px;
      @(negedge clk_in);
      rst_in          = rst;
      bus.hcount_in   = 11'(h);
      bus.vcount_in   = 10'(v);
      bus.hsync_in    = hs;
      bus.vsync_in    = vs;
      bus.active_in   = act;
      bus.swap_req_in = req;
      if (rst) begin
         m_valid = 0; m_known = 1; m_addr = '0;
         m_bank = 0; m_pend = 0; m_prev_vs = 0; m_ack = 0;
         for (int i = 0; i < 4; i++) pipe[i] = '0;
      end else begin
         if (h == 0 && v == 0) m_valid = 1;
         region = (h >= X0) && (h < X0 + GRID_W * SCALE) && (v >= Y0) && (v < Y0 + GRID_H * SCALE);
         if (region) begin
            if (m_valid) begin
               m_addr  = 16'(((v - Y0) / SCALE) * GRID_W + (h - X0) / SCALE);
               m_known = 1;
            end else begin
               m_known = 0;
            end
         end
         px = !m_valid ? 24'h0 : (region ? colour(int'(mag_of(m_addr))) : BORDER_RGB);
         if (vs && !m_prev_vs && (m_pend || req)) begin
            m_bank = ~m_bank; m_ack = 1; m_pend = 0;
         end else begin
            m_ack = 0;
            if (req) m_pend = 1;
         end
         m_prev_vs = vs;
         for (int i = 3; i > 0; i--) pipe[i] = pipe[i-1];
         pipe[0] = {hs, vs, act, px};
      end
      @(posedge clk_in);
      #2;
      if (m_known) chk("addr_out", 24'(bus.addr_out), 24'(m_addr));
      chk("bank_out",     24'(bus.bank_out),     24'(m_bank));
      chk("swap_ack_out", 24'(bus.swap_ack_out), 24'(m_ack));
      chk("hsync_out",    24'(bus.hsync_out),    24'(pipe[3].hs));
      chk("vsync_out",    24'(bus.vsync_out),    24'(pipe[3].vs));
      chk("active_out",   24'(bus.active_out),   24'(pipe[3].act));
      chk("pixel_out",    bus.pixel_out,         pipe[3].px);
   endtask

   // One reduced frame: every line gets its hcount 0 cycle; selected lines are scanned.
   task automatic frame(input int req_a, input int req_b, input bit req_rise, input int rst_line);
      bit vs, req, scan, fixed, region;
      int hend;
      for (int v = 0; v <= 652; v++) begin
         vs    = (v >= 650);
         req   = (v == req_a) || (v == req_b) || (req_rise && v == 650);
         fixed = (v == 72) || (v == 75) || (v == 200) || (v == 647) || (v == 648);
         scan  = fixed || (v == 73) || (v == 74) || ($urandom_range(0, 59) == 0);
         hend  = fixed ? 930 : int'($urandom_range(352, 930));
         step(0, 0, v, 1'($urandom_range(0, 1)), vs, 0, req);
         if (scan) begin
            for (int h = 351; h <= hend; h++) begin
               region = (h >= X0) && (h < X0 + GRID_W * SCALE) && (v >= Y0) && (v < Y0 + GRID_H * SCALE);
               step((v == rst_line) && (h == 500), h, v, 1'($urandom_range(0, 1)), vs,
                    region | 1'($urandom_range(0, 1)), 0);
            end
            step(0, 1000, v, 1'($urandom_range(0, 1)), vs, 0, 0);
         end
      end
   endtask

   initial begin
      salt            = $urandom;
      rst_in          = 1'b1;
      bus.hcount_in   = 11'd500;
      bus.vcount_in   = 10'd300;
      bus.hsync_in    = 1'b0;
      bus.vsync_in    = 1'b0;
      bus.active_in   = 1'b0;
      bus.swap_req_in = 1'b0;

      repeat (3) step(1, 500, 300, 0, 0, 0, 0);
      repeat (6) step(0, 500, 300, 1'($urandom_range(0, 1)), 0, 1, 0);

      frame(-1, -1, 0, -1);   // no request: bank stays
      frame(100, -1, 0, -1);  // single mid-frame request
      frame(100, 300, 0, -1); // two requests, one toggle
      frame(-1, -1, 1, -1);   // request on the vsync rise itself
      frame(100, -1, 0, 200); // reset mid-line drops the pending request
      frame(-1, 400, 0, -1);  // counters re-synchronised after the reset

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
